alu_arbiter: RTL
================

# alu_arbiter

Shares one 4-bit `ALU` instance between two independent requesters. Each request carries operands and an op select; each response carries the 8-bit result. The block accepts one request at a time, drives the ALU operand/select lines from registered values, captures the result and returns it through a valid/ready response handshake. Arbitration is round-robin. It sits between client logic and the existing `ALU`, whose ports connect directly to `alu_a_o`, `alu_b_o`, `alu_opsel_o` and `alu_r_i`.

## Interface
- `DATA_W`, 4, ALU operand width.
- `OP_W`, 3, ALU op select width.
- `RES_W`, 8, ALU result width.
- `CNT_W`, 8, width of the completed-operation counter.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_n_i`  in  1  reset; asynchronous, active-low.
- `reqN_valid_i` (N=0,1)  in  1  request N valid.
- `reqN_ready_o`  out  1  request N accepted this cycle when high together with `reqN_valid_i`.
- `reqN_a_i`, `reqN_b_i`  in  DATA_W  operands.
- `reqN_opsel_i`  in  OP_W  op select, passed to the ALU unmodified.
- `rspN_valid_o`  out  1  result for requester N available.
- `rspN_ready_i`  in  1  requester N consumes the result.
- `rsp_data_o`  out  RES_W  captured result; shared by both response ports.
- `alu_a_o`, `alu_b_o`  out  DATA_W  to ALU `A_i`, `B_i`.
- `alu_opsel_o`  out  OP_W  to ALU `opSel`.
- `alu_r_i`  in  RES_W  from ALU `r_alu`.
- `busy_o`  out  1  high whenever the state is not IDLE.
- `ops_done_o`  out  CNT_W  completed responses; wraps modulo 2^CNT_W.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - The winner of the arbitration sees `reqN_ready_o`=1. Both ready outputs are 0 when neither request is valid.
  - Arbitration with one valid request: that requester wins.
  - Arbitration with both valid: the requester other than `last_grant` wins.
  - On handshake: latch a/b/opsel into the operand registers, record the grant index, go to EXEC.
- **EXEC:** operand registers drive the `alu_*` outputs. At the end of the cycle, capture `alu_r_i` into the result register and go to RESP.
- **RESP:**
  - `rspG_valid_o`=1 for the granted G only; `rsp_data_o` holds the result stable.
  - On `rspG_ready_i`=1: increment `ops_done_o`, set `last_grant`=G, go to IDLE.
  - `rsp_ready` of the non-granted port is ignored.
- Requests presented while busy wait; `ready` stays 0. Requesters hold valid and payload until ready; the arbiter does not require this for correctness.
- `ready` may depend combinationally on both valids. No output depends combinationally on `alu_r_i` or `rspN_ready_i`.
- Reset values:
  - state IDLE; `last_grant`=1, so requester 0 wins the first tie.
  - all outputs 0.
  - operand and result registers 0, so `alu_*_o` are 0.
- Reset asserted mid-transaction aborts it. No response is issued and the counter is not incremented.

## Timing
- Request accepted at edge E0.
- EXEC during cycle E0–E1: `alu_*_o` valid.
- Result captured at E1; `rsp_valid` high from E1.
- With `rsp_ready` already high: completes at E2 and returns to IDLE. The next request can be accepted at E3 at the earliest. Sustained throughput is one operation per 3 cycles.
- Backpressure: RESP holds indefinitely; data and valid are stable until the handshake.
- `ops_done_o` updates at the response handshake edge; after 255 it wraps to 0.

## Structure
- Shared package `alu_pkg`:
  - `DATA_W`, `OP_W`, `RES_W` constants.
  - state enum typedef (IDLE/EXEC/RESP).
  - operand-bundle typedef {a, b, opsel}.
- One sub-module: `rr_arb2`, a combinational two-way round-robin grant taking valid[1:0] and `last_grant` and producing one-hot grant[1:0].
- The `ALU` is not instantiated inside this block. The integration top connects it.

## Test plan
- **Reset:** hold `rst_n_i` low with both valids high. Expect all outputs 0 and `ready` 0. After release, `req0_ready_o`=1 and `req1_ready_o`=0 in the first cycle.
- **Single request:**
  - req0 with a=4'h3, b=4'h5, opsel=3'd0; bench ALU stub returns 8'h08 one delta after inputs.
  - Expect `alu_a_o`=3 and `alu_b_o`=5 during EXEC.
  - Expect `rsp0_valid_o` at E1 with `rsp_data_o`=8'h08, `rsp1_valid_o`=0, and `ops_done_o`=1 after the handshake.
- **Fairness:** both requesters valid continuously for 4 transactions. Expect grant order 0,1,0,1 and every response routed to the correct port.
- **Backpressure:** hold `rsp1_ready_i`=0 for 10 cycles after `rsp1_valid_o`. Expect valid and data stable, `busy_o`=1, and `req0_ready_o`=0 throughout. Release: IDLE next cycle.
- **Reset mid-op:** assert reset during EXEC. Expect no response, `ops_done_o`=0, and the first tie after release granted to 0.
- **Counter wrap:** run 257 single transactions. Expect `ops_done_o`=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths, FSM state and operand bundle for the ALU arbiter.
// No logic; types only.
// Imported by alu_arbiter and its sub-module.
package alu_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 3;
  localparam int RES_W  = 8;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   opsel;
  } operand_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone valid wins, a tie goes to the side not granted last.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with its own state.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant; tie broken against the previous winner
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters with round-robin arbitration.
// Latency: accept at E0, ALU driven E0-E1, result valid from E1; one op per 3 cycles at best.
// Backpressure: RESP holds result/valid until the granted requester takes it; requests wait with ready low.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int CNT_W_P = CNT_W
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                req0_valid_i,
  output logic                req0_ready_o,
  input  logic [DATA_W-1:0]   req0_a_i,
  input  logic [DATA_W-1:0]   req0_b_i,
  input  logic [OP_W-1:0]     req0_opsel_i,
  input  logic                req1_valid_i,
  output logic                req1_ready_o,
  input  logic [DATA_W-1:0]   req1_a_i,
  input  logic [DATA_W-1:0]   req1_b_i,
  input  logic [OP_W-1:0]     req1_opsel_i,
  output logic                rsp0_valid_o,
  input  logic                rsp0_ready_i,
  output logic                rsp1_valid_o,
  input  logic                rsp1_ready_i,
  output logic [RES_W-1:0]    rsp_data_o,
  output logic [DATA_W-1:0]   alu_a_o,
  output logic [DATA_W-1:0]   alu_b_o,
  output logic [OP_W-1:0]     alu_opsel_o,
  input  logic [RES_W-1:0]    alu_r_i,
  output logic                busy_o,
  output logic [CNT_W_P-1:0]  ops_done_o
);

  state_t               state_q;
  state_t               state_d;
  operand_t             opnd_q;
  logic [RES_W-1:0]     res_q;
  logic                 gnt_q;
  logic                 last_grant_q;
  logic [CNT_W_P-1:0]   cnt_q;
  logic [1:0]           grant;
  logic                 accept;
  logic                 done;
  logic                 gnt_rsp_ready;

  rr_arb2 u_rr_arb2 (
    .valid      ({req1_valid_i, req0_valid_i}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign gnt_rsp_ready = gnt_q ? rsp1_ready_i : rsp0_ready_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake strobes; ready masked while reset is held so outputs stay 0
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    done         = 1'b0;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready_o = grant[0] & rst_n_i;
        req1_ready_o = grant[1] & rst_n_i;
        if ((|grant) && rst_n_i) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (gnt_rsp_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand latch, result capture, grant bookkeeping and completion counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      opnd_q       <= '0;
      res_q        <= '0;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      if (accept) begin
        gnt_q <= grant[1];
        if (grant[1]) begin
          opnd_q <= '{a: req1_a_i, b: req1_b_i, opsel: req1_opsel_i};
        end else begin
          opnd_q <= '{a: req0_a_i, b: req0_b_i, opsel: req0_opsel_i};
        end
      end
      if (state_q == EXEC) begin
        res_q <= alu_r_i;
      end
      if (done) begin
        cnt_q        <= cnt_q + 1'b1;
        last_grant_q <= gnt_q;
      end
    end
  end

  assign alu_a_o      = opnd_q.a;
  assign alu_b_o      = opnd_q.b;
  assign alu_opsel_o  = opnd_q.opsel;
  assign rsp_data_o   = res_q;
  assign rsp0_valid_o = (state_q == RESP) && !gnt_q;
  assign rsp1_valid_o = (state_q == RESP) && gnt_q;
  assign busy_o       = (state_q != IDLE);
  assign ops_done_o   = cnt_q;

endmodule
